prng_byte_packer: RTL and testbench

PRNG_BYTE_PACKER -- requirements
Module: prng_byte_packer

---
 rtl/prng_byte_packer.sv | 121 ++++++++++++
 tb/tb_prng_byte_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prng_byte_packer.sv
// Packs a serial LFSR bit stream LSB-first into WIDTH-bit words and buffers
// them in a 2-entry in-order FIFO with a saturating overflow drop counter.
module prng_byte_packer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic [1:0]       fifo_cnt,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0]       drop_q, drop_d;

    logic [WIDTH-1:0] word;
    logic             push;
    logic             pop;

    always_comb begin
        word      = partial_q;
        word[bit_idx_q] = bit_in;
        push      = bit_en && (bit_idx_q == LAST_IDX);
        pop       = (cnt_q != 2'd0) && data_ready;

        bit_idx_d = bit_idx_q;
        partial_d = partial_q;
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;

        if (bit_en) begin
            if (push) begin
                bit_idx_d = '0;
                partial_d = '0;
            end else begin
                bit_idx_d = bit_idx_q + 1'b1;
                partial_d = word;
            end
        end

        // Empty slots are kept at zero so data_out reads 0 with no valid word.
        unique case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = word;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = word;
                end else if (push) begin
                    tail_d = word;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    head_d = '0;
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (push && pop) begin
                    head_d = tail_q;
                    tail_d = word;
                end else if (push) begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end else if (pop) begin
                    head_d = tail_q;
                    tail_d = '0;
                    cnt_d  = 2'd1;
                end
            end
        endcase

        if (sync_clr) begin
            bit_idx_d = '0;
            partial_d = '0;
            head_d    = '0;
            tail_d    = '0;
            cnt_d     = 2'd0;
            drop_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            bit_idx_q <= '0;
            partial_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= 2'd0;
            drop_q    <= '0;
        end else begin
            bit_idx_q <= bit_idx_d;
            partial_q <= partial_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
        end
    end

    assign data_out   = head_q;
    assign data_valid = (cnt_q != 2'd0);
    assign fifo_cnt   = cnt_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_prng_byte_packer.sv
// Directed self-checking bench for prng_byte_packer (WIDTH=8).
module tb_prng_byte_packer;

    logic       clk = 1'b0;
    logic       _rst;
    logic       bit_in;
    logic       bit_en;
    logic       sync_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [1:0] fifo_cnt;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    prng_byte_packer #(.WIDTH(8)) dut (
        .clk        (clk),
        ._rst       (_rst),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .sync_clr   (sync_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .fifo_cnt   (fifo_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            bit_en = 1'b1;
            bit_in = w[i];
            tick();
        end
        bit_en = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic do_clr();
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        total++; if (fifo_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'h4D;
        data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bit_en = 1'b1;
            bit_in = w[i];
            tick();
            if (i == 6) begin
                total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", data_valid); end
            end
        end
        bit_en = 1'b0;
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", data_valid); end
        total++; if (data_out !== 8'h4D) begin bad++; $display("FAIL basic_out got=%h exp=4d", data_out); end
        tick();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b exp=0", data_valid); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL basic_empty_out got=%h exp=00", data_out); end
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        w = 8'h4D;
        data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bit_en = 1'b1;
            bit_in = w[i];
            tick();
            if (i < 7) begin
                bit_en = 1'b0;
                bit_in = ~w[i];
                tick();
            end
            if (i == 6) begin
                total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL gaps_early_valid got=%b exp=0", data_valid); end
            end
        end
        bit_en = 1'b0;
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b exp=1", data_valid); end
        total++; if (data_out !== 8'h4D) begin bad++; $display("FAIL gaps_out got=%h exp=4d", data_out); end
        tick();
    endtask

    task automatic test_overflow_order();
        do_clr();
        data_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        tick();
        tick();
        total++; if (fifo_cnt !== 2'd2) begin bad++; $display("FAIL ovf_cnt got=%0d exp=2", fifo_cnt); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ovf_drop got=%0d exp=1", drop_cnt); end
        total++; if (data_out !== 8'h11) begin bad++; $display("FAIL ovf_head_stable got=%h exp=11", data_out); end
        data_ready = 1'b1;
        tick();
        total++; if (data_out !== 8'h22) begin bad++; $display("FAIL ovf_second got=%h exp=22", data_out); end
        total++; if (fifo_cnt !== 2'd1) begin bad++; $display("FAIL ovf_cnt1 got=%0d exp=1", fifo_cnt); end
        tick();
        total++; if (fifo_cnt !== 2'd0) begin bad++; $display("FAIL ovf_drain got=%0d exp=0", fifo_cnt); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL ovf_drain_out got=%h exp=00", data_out); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] w;
        do_clr();
        data_ready = 1'b0;
        send_word(8'hAA);
        send_word(8'h55);
        w = 8'hF0;
        for (int i = 0; i < 8; i++) begin
            bit_en = 1'b1;
            bit_in = w[i];
            data_ready = (i == 7);
            tick();
        end
        bit_en = 1'b0;
        data_ready = 1'b0;
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL full_pp_drop got=%0d exp=0", drop_cnt); end
        total++; if (fifo_cnt !== 2'd2) begin bad++; $display("FAIL full_pp_cnt got=%0d exp=2", fifo_cnt); end
        total++; if (data_out !== 8'h55) begin bad++; $display("FAIL full_pp_second got=%h exp=55", data_out); end
        data_ready = 1'b1;
        tick();
        total++; if (data_out !== 8'hF0) begin bad++; $display("FAIL full_pp_third got=%h exp=f0", data_out); end
        tick();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL full_pp_drain got=%b exp=0", data_valid); end
    endtask

    task automatic test_saturation();
        do_clr();
        data_ready = 1'b0;
        for (int n = 0; n < 302; n++) begin
            send_word(8'h5A);
            if (n == 255) begin
                total++; if (drop_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", drop_cnt); end
            end
        end
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", drop_cnt); end
        total++; if (fifo_cnt !== 2'd2) begin bad++; $display("FAIL sat_cnt got=%0d exp=2", fifo_cnt); end
        data_ready = 1'b1;
        do_clr();
        data_ready = 1'b0;
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL clr_drop got=%0d exp=0", drop_cnt); end
        total++; if (fifo_cnt !== 2'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", fifo_cnt); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", data_valid); end
    endtask

    task automatic test_clr_priority();
        do_clr();
        data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_en = 1'b1;
            bit_in = 1'b1;
            tick();
        end
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        bit_en = 1'b0;
        send_word(8'h0F);
        tick();
        total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL clr_prio_out got=%h exp=0f", data_out); end
        total++; if (fifo_cnt !== 2'd1) begin bad++; $display("FAIL clr_prio_cnt got=%0d exp=1", fifo_cnt); end
    endtask

    task automatic test_async_reset();
        do_clr();
        data_ready = 1'b0;
        send_word(8'h81);
        send_word(8'h7E);
        send_word(8'h3C);
        for (int i = 0; i < 5; i++) begin
            bit_en = 1'b1;
            bit_in = i[0];
            tick();
        end
        bit_en = 1'b0;
        #2;
        _rst = 1'b0;
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL arst_out got=%h exp=00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", data_valid); end
        total++; if (fifo_cnt !== 2'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", fifo_cnt); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL arst_drop got=%0d exp=0", drop_cnt); end
        tick();
        #2;
        _rst = 1'b1;
        send_word(8'hFF);
        total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL arst_after got=%h exp=ff", data_out); end
        total++; if (fifo_cnt !== 2'd1) begin bad++; $display("FAIL arst_after_cnt got=%0d exp=1", fifo_cnt); end
    endtask

    initial begin
        _rst = 1'b0;
        bit_in = 1'b0;
        bit_en = 1'b0;
        sync_clr = 1'b0;
        data_ready = 1'b0;
        #12;
        test_reset();
        _rst = 1'b1;
        test_basic();
        test_gaps();
        test_overflow_order();
        test_push_pop_full();
        test_saturation();
        test_clr_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
